// File: rtl/dlx_pkg.sv
// Shared DLX definitions: fetch-state encoding, default datapath widths and reset PC.
package dlx_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_FLUSH = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

  localparam int unsigned DLX_ADDR_W   = 32;
  localparam int unsigned DLX_INST_W   = 32;
  localparam logic [31:0] DLX_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/dlx_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and single-cycle flush.
module dlx_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full;
  logic             do_push, do_pop;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem[rd_ptr_q];

  // Flush wins over any push or pop presented in the same cycle.
  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dlx_fetch_queue.sv
// DLX fetch stage with decoupled prefetch queue, credit-limited issue and redirect flush.
// Define FETCH_PERF_CNT_EN to add stall_cnt/flush_cnt performance counters.
module dlx_fetch_queue
  import dlx_pkg::*;
#(
  parameter int unsigned        ADDR_W   = DLX_ADDR_W,
  parameter int unsigned        INST_W   = DLX_INST_W,
  parameter int unsigned        PC_INC   = 1,
  parameter int unsigned        FQ_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DLX_RESET_PC)
) (
  input  logic                          clock1,
  input  logic                          reset1,
  input  logic                          jump_en,
  input  logic                          branch_en,
  input  logic [ADDR_W-1:0]             target_in,
  input  logic                          halt_in,
  output logic                          imem_req,
  output logic [ADDR_W-1:0]             imem_addr,
  input  logic                          imem_rvalid,
  input  logic [INST_W-1:0]             imem_rdata,
  output logic                          dec_valid,
  input  logic                          dec_ready,
  output logic [INST_W-1:0]             irout,
  output logic [ADDR_W-1:0]             npcout,
  output logic [$clog2(FQ_DEPTH):0]     fq_count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                   stall_cnt,
  output logic [31:0]                   flush_cnt
`endif
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned QW = ADDR_W + INST_W;

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]      drop_cnt_q, drop_cnt_d;

  logic               redirect, issue, credit_ok, rsp_drop;
  logic [CW:0]        in_use;
  logic               q_push, q_pop, q_flush, q_empty;
  logic [QW-1:0]      q_head;
  logic [CW-1:0]      q_count;
  logic               if_pop, if_flush, if_empty;
  logic [ADDR_W-1:0]  if_head;
  logic [CW-1:0]      if_count;

  assign redirect = jump_en | branch_en;
  assign in_use   = {1'b0, if_count} + {1'b0, q_count};
  assign credit_ok = (in_use < (CW+1)'(FQ_DEPTH));

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    issue      = 1'b0;
    rsp_drop   = 1'b0;
    q_push     = 1'b0;
    q_pop      = 1'b0;
    q_flush    = 1'b0;
    if_pop     = 1'b0;
    if_flush   = 1'b0;
    if (redirect) begin
      q_flush    = 1'b1;
      if_flush   = 1'b1;
      fetch_pc_d = target_in;
      // Requests already in flight become responses to throw away.
      if (state_q == S_FLUSH) begin
        rsp_drop   = imem_rvalid && (drop_cnt_q != '0);
        drop_cnt_d = drop_cnt_q - CW'(rsp_drop);
      end else begin
        rsp_drop   = imem_rvalid && !if_empty;
        drop_cnt_d = if_count - CW'(rsp_drop);
      end
      state_d = (drop_cnt_d != '0) ? S_FLUSH : S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          issue = !halt_in && credit_ok;
          if (halt_in) state_d = S_HALT;
        end
        S_HALT: begin
          if (!halt_in) state_d = S_FETCH;
        end
        S_FLUSH: begin
          rsp_drop   = imem_rvalid && (drop_cnt_q != '0);
          drop_cnt_d = drop_cnt_q - CW'(rsp_drop);
          if (drop_cnt_d == '0) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
      if (state_q != S_FLUSH) begin
        if_pop = imem_rvalid && !if_empty;
        q_push = if_pop;
      end
      q_pop = dec_valid && dec_ready;
      if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
    end
  end

  always_ff @(posedge clock1 or posedge reset1) begin
    if (reset1) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  dlx_sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (FQ_DEPTH)
  ) u_inflight (
    .clk       (clock1),
    .rst       (reset1),
    .push      (issue),
    .push_data (fetch_pc_q),
    .pop       (if_pop),
    .flush     (if_flush),
    .head_data (if_head),
    .empty     (if_empty),
    .count     (if_count)
  );

  dlx_sync_fifo #(
    .WIDTH (QW),
    .DEPTH (FQ_DEPTH)
  ) u_prefetch (
    .clk       (clock1),
    .rst       (reset1),
    .push      (q_push),
    .push_data ({if_head, imem_rdata}),
    .pop       (q_pop),
    .flush     (q_flush),
    .head_data (q_head),
    .empty     (q_empty),
    .count     (q_count)
  );

  // The request strobe is combinational, so hold it low while reset is asserted.
  assign imem_req  = issue && !reset1;
  assign imem_addr = fetch_pc_q;
  assign dec_valid = !q_empty;
  assign irout     = dec_valid ? q_head[INST_W-1:0] : '0;
  assign npcout    = dec_valid ? q_head[INST_W +: ADDR_W] : '0;
  assign fq_count  = q_count;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (dec_valid && !dec_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (rsp_drop && (flush_cnt_q != '1))                flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clock1 or posedge reset1) begin
    if (reset1) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_dlx_fetch_queue.sv
// Directed bench for dlx_fetch_queue: vector table for streaming/redirect/wrap/halt, plus
// hand sequences for flush with latency 3, back-pressure fill and reset while full.
module tb_dlx_fetch_queue;

  logic        clock1, reset1;
  logic        jump_en, branch_en, halt_in, dec_ready;
  logic [31:0] target_in;
  logic        imem_req, imem_rvalid, dec_valid;
  logic [31:0] imem_addr, imem_rdata, irout, npcout;
  logic [2:0]  fq_count;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  dlx_fetch_queue dut (
    .clock1      (clock1),
    .reset1      (reset1),
    .jump_en     (jump_en),
    .branch_en   (branch_en),
    .target_in   (target_in),
    .halt_in     (halt_in),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .irout       (irout),
    .npcout      (npcout),
    .fq_count    (fq_count)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  initial clock1 = 1'b0;
  always #5 clock1 = ~clock1;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } req_t;

  // ctl = {reset1, jump_en, branch_en, halt_in, dec_ready}
  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_dv;
    logic [31:0] e_npc;
    logic [2:0]  e_cnt;
  } vec_t;

  req_t        pipe[$];
  vec_t        tv[$];
  int          cyc, lat, n_chk, n_err;
  logic        s_req, s_dv;
  logic [31:0] s_addr, s_ir, s_npc;
  logic [2:0]  s_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs after the edge, answer imem in order, sample at negedge.
  task automatic step(input logic [4:0] ctl, input logic [31:0] tgt);
    @(posedge clock1);
    #1;
    reset1    = ctl[4];
    jump_en   = ctl[3];
    branch_en = ctl[2];
    halt_in   = ctl[1];
    dec_ready = ctl[0];
    target_in = tgt;
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (ctl[4]) begin
      pipe.delete();
    end else if (pipe.size() > 0 && pipe[0].due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ~pipe[0].addr;
      void'(pipe.pop_front());
    end
    @(negedge clock1);
    s_req  = imem_req;
    s_addr = imem_addr;
    s_dv   = dec_valid;
    s_ir   = irout;
    s_npc  = npcout;
    s_cnt  = fq_count;
    if (imem_req && !ctl[4]) pipe.push_back('{due: cyc + lat, addr: imem_addr});
  endtask

  initial begin
    int   nreq, nstall, addr_bad, waited;
    logic found;
    reset1 = 1'b1; jump_en = 1'b0; branch_en = 1'b0; halt_in = 1'b0; dec_ready = 1'b0;
    target_in = '0; imem_rvalid = 1'b0; imem_rdata = '0;
    cyc = 0; n_chk = 0; n_err = 0; lat = 1;

    // Streaming, jump+branch collision with rvalid and pop, PC wrap, halt mid-stream.
    tv.push_back('{5'b10001, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         3'd0});
    tv.push_back('{5'b00001, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         3'd0});
    tv.push_back('{5'b00001, 32'h0,         1'b1, 32'h1,         1'b0, 32'h0,         3'd0});
    tv.push_back('{5'b00001, 32'h0,         1'b1, 32'h2,         1'b1, 32'h0,         3'd1});
    tv.push_back('{5'b00001, 32'h0,         1'b1, 32'h3,         1'b1, 32'h1,         3'd1});
    tv.push_back('{5'b01101, 32'h80,        1'b0, 32'h4,         1'b1, 32'h2,         3'd1});
    tv.push_back('{5'b00001, 32'h0,         1'b1, 32'h80,        1'b0, 32'h0,         3'd0});
    tv.push_back('{5'b00001, 32'h0,         1'b1, 32'h81,        1'b0, 32'h0,         3'd0});
    tv.push_back('{5'b00001, 32'h0,         1'b1, 32'h82,        1'b1, 32'h80,        3'd1});
    tv.push_back('{5'b00001, 32'h0,         1'b1, 32'h83,        1'b1, 32'h81,        3'd1});
    tv.push_back('{5'b01001, 32'hFFFF_FFFE, 1'b0, 32'h84,        1'b1, 32'h82,        3'd1});
    tv.push_back('{5'b00001, 32'h0,         1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0,         3'd0});
    tv.push_back('{5'b00001, 32'h0,         1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,         3'd0});
    tv.push_back('{5'b00001, 32'h0,         1'b1, 32'h0,         1'b1, 32'hFFFF_FFFE, 3'd1});
    tv.push_back('{5'b00011, 32'h0,         1'b0, 32'h1,         1'b1, 32'hFFFF_FFFF, 3'd1});
    tv.push_back('{5'b00011, 32'h0,         1'b0, 32'h1,         1'b1, 32'h0,         3'd1});
    tv.push_back('{5'b00001, 32'h0,         1'b0, 32'h1,         1'b0, 32'h0,         3'd0});
    tv.push_back('{5'b00001, 32'h0,         1'b1, 32'h1,         1'b0, 32'h0,         3'd0});
    tv.push_back('{5'b00001, 32'h0,         1'b1, 32'h2,         1'b0, 32'h0,         3'd0});
    tv.push_back('{5'b00001, 32'h0,         1'b1, 32'h3,         1'b1, 32'h1,         3'd1});

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].ctl, tv[i].tgt);
      $display("row %0d ctl=%b req=%0b addr=%h dv=%0b npc=%h ir=%h cnt=%0d",
               i, tv[i].ctl, s_req, s_addr, s_dv, s_npc, s_ir, s_cnt);
      chk($sformatf("row%0d_req", i),  32'(s_req),  32'(tv[i].e_req));
      chk($sformatf("row%0d_addr", i), s_addr,      tv[i].e_addr);
      chk($sformatf("row%0d_dv", i),   32'(s_dv),   32'(tv[i].e_dv));
      chk($sformatf("row%0d_cnt", i),  32'(s_cnt),  32'(tv[i].e_cnt));
      if (tv[i].e_dv) begin
        chk($sformatf("row%0d_npc", i), s_npc, tv[i].e_npc);
        chk($sformatf("row%0d_ir", i),  s_ir,  ~tv[i].e_npc);
      end
    end

    // Latency 3: branch while three requests are in flight, one response landing that cycle.
    lat = 3;
    step(5'b10001, 32'h0);
    step(5'b00001, 32'h0);
    chk("t3_c0_addr", s_addr, 32'h0);
    step(5'b00001, 32'h0);
    step(5'b00001, 32'h0);
    chk("t3_c2_req", 32'(s_req), 32'd1);
    step(5'b00101, 32'h40);
    $display("t3 branch cycle req=%0b addr=%h", s_req, s_addr);
    chk("t3_branch_req", 32'(s_req), 32'd0);
    step(5'b00001, 32'h0);
    chk("t3_flush1_req", 32'(s_req), 32'd0);
    chk("t3_flush1_dv",  32'(s_dv),  32'd0);
    step(5'b00001, 32'h0);
    chk("t3_flush2_req", 32'(s_req), 32'd0);
    chk("t3_flush2_dv",  32'(s_dv),  32'd0);
    step(5'b00001, 32'h0);
    $display("t3 resume req=%0b addr=%h", s_req, s_addr);
    chk("t3_resume_req",  32'(s_req), 32'd1);
    chk("t3_resume_addr", s_addr,     32'h40);
`ifdef FETCH_PERF_CNT_EN
    chk("t3_flush_cnt", flush_cnt, 32'd3);
`endif
    found = 1'b0;
    waited = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      step(5'b00001, 32'h0);
      waited++;
      if (s_dv) found = 1'b1;
    end
    $display("t3 first decode after %0d cycles npc=%h ir=%h", waited, s_npc, s_ir);
    chk("t3_dv_seen",    32'(found),  32'd1);
    chk("t3_dv_latency", 32'(waited), 32'd4);
    chk("t3_first_npc",  s_npc,       32'h40);
    chk("t3_first_ir",   s_ir,        ~32'h40);

    // Decode stalled: credit limit caps issue at FQ_DEPTH requests.
    lat = 1;
    step(5'b10000, 32'h0);
    nreq = 0; nstall = 0; addr_bad = 0;
    for (int k = 0; k < 20; k++) begin
      step(5'b00000, 32'h0);
      if (s_req) begin
        if (s_addr != 32'(nreq)) addr_bad++;
        nreq++;
      end
      if (s_dv) nstall++;
    end
    $display("t2 reqs=%0d cnt=%0d req=%0b dv=%0b npc=%h", nreq, s_cnt, s_req, s_dv, s_npc);
    chk("t2_num_req",  32'(nreq),     32'd4);
    chk("t2_addr_seq", 32'(addr_bad), 32'd0);
    chk("t2_cnt_full", 32'(s_cnt),    32'd4);
    chk("t2_req_low",  32'(s_req),    32'd0);
    chk("t2_dv",       32'(s_dv),     32'd1);
    chk("t2_head_npc", s_npc,         32'h0);
`ifdef FETCH_PERF_CNT_EN
    step(5'b00000, 32'h0);
    chk("t2_stall_cnt", stall_cnt, 32'(nstall));
`endif

    // Reset asserted while the queue is full: outputs return to reset values at once.
    step(5'b10000, 32'h0);
    $display("t6 reset req=%0b addr=%h dv=%0b npc=%h ir=%h cnt=%0d",
             s_req, s_addr, s_dv, s_npc, s_ir, s_cnt);
    chk("t6_req",  32'(s_req), 32'd0);
    chk("t6_addr", s_addr,     32'h0);
    chk("t6_dv",   32'(s_dv),  32'd0);
    chk("t6_ir",   s_ir,       32'h0);
    chk("t6_npc",  s_npc,      32'h0);
    chk("t6_cnt",  32'(s_cnt), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("t6_stall_cnt", stall_cnt, 32'd0);
    chk("t6_flush_cnt", flush_cnt, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
